// File: rtl/time_text_streamer.sv
// BCD time-of-day counter feeding a 64-character OLED text stream ("HH:MM:SS" + 56 spaces per frame).
// Optional macro TWELVE_HOUR_EN: 12-hour count (12,01..11), blanked leading hour digit, live pm flag.
module time_text_streamer #(
    parameter int CLK_HZ = 100000000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       inc_min,
    input  logic       inc_hour,
    output logic [6:0] sendData,
    output logic       sendDataValid,
    input  logic       sendDone,
    output logic       sec_tick,
    output logic       frame_start,
    output logic       pm
);
    // state | meaning
    // SNAP  | valid low; first cycle arms frame_start, the armed cycle latches the snapshot
    // SEND  | char(idx) held on sendData until sendDone; idx 63 + sendDone returns to SNAP

    localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0] PRE_LOAD = PW'(CLK_HZ - 1);
`ifdef TWELVE_HOUR_EN
    localparam logic [7:0] HOUR_INIT = 8'h12;
`else
    localparam logic [7:0] HOUR_INIT = 8'h00;
`endif

    typedef enum logic {SNAP, SEND} state_t;

    state_t        state, state_next;
    logic [PW-1:0] pre_cnt, pre_next;
    logic [7:0]    hours, minutes, seconds;
    logic [7:0]    hours_next, minutes_next, seconds_next;
    logic [7:0]    snap_h, snap_m, snap_s;
    logic [5:0]    idx, idx_next;
    logic [6:0]    data_next;
    logic          tick, set_pulse, hour_step;
    logic          fs_next, snap_load;

    function automatic logic [7:0] bcd60_inc(input logic [7:0] v);
        if (v == 8'h59) return 8'h00;
        if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
        return v + 8'd1;
    endfunction

    function automatic logic [7:0] hour_inc(input logic [7:0] h);
`ifdef TWELVE_HOUR_EN
        if (h == 8'h12) return 8'h01;
        if (h == 8'h11) return 8'h12;
`else
        if (h == 8'h23) return 8'h00;
`endif
        if (h[3:0] == 4'd9) return {h[7:4] + 4'd1, 4'd0};
        return h + 8'd1;
    endfunction

    function automatic logic [6:0] char_at(input logic [5:0] i, input logic [7:0] h,
                                           input logic [7:0] m, input logic [7:0] s);
        logic [6:0] c;
        c = 7'h20;
        case (i)
            6'd0:       c = {3'b011, h[7:4]};
            6'd1:       c = {3'b011, h[3:0]};
            6'd2, 6'd5: c = 7'h3A;
            6'd3:       c = {3'b011, m[7:4]};
            6'd4:       c = {3'b011, m[3:0]};
            6'd6:       c = {3'b011, s[7:4]};
            6'd7:       c = {3'b011, s[3:0]};
            default:    c = 7'h20;
        endcase
`ifdef TWELVE_HOUR_EN
        if (i == 6'd0 && h[7:4] == 4'd0) c = 7'h20;
`endif
        return c;
    endfunction

    // A set pulse wins over a same-cycle tick: seconds and prescaler restart together.
    always_comb begin
        set_pulse    = inc_min | inc_hour;
        tick         = 1'b0;
        hour_step    = 1'b0;
        pre_next     = pre_cnt - PW'(1);
        seconds_next = seconds;
        minutes_next = minutes;
        if (set_pulse) begin
            pre_next     = PRE_LOAD;
            seconds_next = 8'h00;
            if (inc_min) minutes_next = bcd60_inc(minutes);
            hour_step = inc_hour;
        end else if (pre_cnt == '0) begin
            tick         = 1'b1;
            pre_next     = PRE_LOAD;
            seconds_next = bcd60_inc(seconds);
            if (seconds == 8'h59) begin
                minutes_next = bcd60_inc(minutes);
                hour_step    = (minutes == 8'h59);
            end
        end
        hours_next = hour_step ? hour_inc(hours) : hours;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pre_cnt  <= PRE_LOAD;
            hours    <= HOUR_INIT;
            minutes  <= 8'h00;
            seconds  <= 8'h00;
            sec_tick <= 1'b0;
        end else begin
            pre_cnt  <= pre_next;
            hours    <= hours_next;
            minutes  <= minutes_next;
            seconds  <= seconds_next;
            sec_tick <= tick;
        end
    end

`ifdef TWELVE_HOUR_EN
    logic pm_q;
    always_ff @(posedge clock or posedge reset) begin
        if (reset) pm_q <= 1'b0;
        else if (hour_step && hours == 8'h11) pm_q <= ~pm_q;
    end
    assign pm = pm_q;
`else
    assign pm = 1'b0;
`endif

    always_comb begin
        state_next = state;
        idx_next   = idx;
        data_next  = sendData;
        fs_next    = 1'b0;
        snap_load  = 1'b0;
        case (state)
            SNAP: begin
                if (!frame_start) begin
                    fs_next = 1'b1;
                end else begin
                    // Snapshot sees this cycle's time update, so char 0 is built from *_next.
                    snap_load  = 1'b1;
                    idx_next   = 6'd0;
                    data_next  = char_at(6'd0, hours_next, minutes_next, seconds_next);
                    state_next = SEND;
                end
            end
            SEND: begin
                if (sendDone) begin
                    if (idx == 6'd63) begin
                        state_next = SNAP;
                        fs_next    = 1'b1;
                    end else begin
                        idx_next  = idx + 6'd1;
                        data_next = char_at(idx + 6'd1, snap_h, snap_m, snap_s);
                    end
                end
            end
            default: state_next = SNAP;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= SNAP;
            idx         <= 6'd0;
            sendData    <= 7'h20;
            frame_start <= 1'b0;
            snap_h      <= HOUR_INIT;
            snap_m      <= 8'h00;
            snap_s      <= 8'h00;
        end else begin
            state       <= state_next;
            idx         <= idx_next;
            sendData    <= data_next;
            frame_start <= fs_next;
            if (snap_load) begin
                snap_h <= hours_next;
                snap_m <= minutes_next;
                snap_s <= seconds_next;
            end
        end
    end

    assign sendDataValid = (state == SEND);

endmodule

// File: doc/time_text_streamer.md
# time_text_streamer

Timekeeping and character-stream source for the digital clock. Keeps a BCD hours:minutes:seconds count from a prescaled system clock and streams 7-bit ASCII codes into the OLED controller's `sendData`/`sendDataValid`/`sendDone` handshake, 64 characters per display frame. Characters 0–7 of each frame are a snapshot of the time as `HH:MM:SS`; characters 8–63 are spaces.

## Interface
- `CLK_HZ`, default 100000000: system clock cycles per second tick; must be ≥2.
- `clock`  in  1  system clock, 100 MHz.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `inc_min`  in  1  single-cycle, debounced pulse; set minutes.
- `inc_hour`  in  1  single-cycle, debounced pulse; set hours.
- `sendData`  out  7  ASCII code for the OLED controller.
- `sendDataValid`  out  1  character on `sendData` is valid.
- `sendDone`  in  1  one-cycle acknowledge from the OLED controller.
- `sec_tick`  out  1  one-cycle pulse on each seconds increment.
- `frame_start`  out  1  one-cycle pulse when the snapshot is taken.
- `pm`  out  1  PM flag. Tied to 0 unless the macro below is defined.

## Operation
- Prescaler: counts 0..`CLK_HZ`-1. The cycle at `CLK_HZ`-1 wraps it to 0 and raises tick.
- Tick: seconds +1. 59→00 carries to minutes. Minutes 59→00 carries to hours. Hours 23→00 wraps. All fields are two BCD digits. `sec_tick` goes high with the update.
- Set pulses: `inc_min` sets minutes +1 mod 60 with no hour carry. `inc_hour` sets hours +1 mod 24. Any set pulse also clears seconds to 00 and the prescaler to 0, and suppresses any tick in the same cycle (no `sec_tick`). If both pulses arrive together, both fields increment.
- Streamer FSM:
  - SNAP: `sendDataValid`=0. Latches hours, minutes and seconds into the snapshot registers, using values after any update in that same cycle. Sets index to 0, pulses `frame_start`, then goes to SEND.
  - SEND: `sendDataValid`=1 and `sendData`=char(index).
    - On `sendDone`=1 with index<63: index +1 and stay in SEND (`sendDataValid` stays high).
    - On `sendDone`=1 with index=63: go to SNAP.
- char(index) mapping:
  - 0 and 1: hour tens and ones as 0x30+digit.
  - 2 and 5: ':' (0x3A).
  - 3 and 4: minute digits. 6 and 7: second digits.
  - 8..63: 0x20.
- `sendData` and the index change only on a cycle where `sendDone`=1. They are stable at all other times while valid is high.
- The OLED controller's page-advance consumes `sendDataValid` without a `sendDone`. This block keeps holding the same character in that case; no special handling is needed.

## Timing
- Reset values:
  - `sendDataValid`=0, `sendData`=0x20, `sec_tick`=0, `frame_start`=0, `pm`=0.
  - Time 00:00:00, prescaler 0, FSM in SNAP.
- First `frame_start` is 1 cycle after reset release. `sendDataValid` rises 1 cycle after that.
- Acknowledge to next character: 0 cycles. The new code is registered on the `sendDone` edge.
- Frame to frame: exactly 1 SNAP cycle with valid low.
- First tick: `CLK_HZ` cycles after reset release or after the last set pulse.
- Displayed time is at most one frame stale. A tick mid-frame never changes characters 0–7 of that frame.
- `sendDone` while in SNAP is ignored.
- Reset mid-frame: valid drops asynchronously and time clears. The OLED controller shares `reset`.

## Configuration
- `TWELVE_HOUR_EN` defined:
  - Hours count 12,01..11.
  - At reset: 12, `pm`=0.
  - 11→12 carry (tick or `inc_hour`) toggles `pm`.
  - Hour tens digit 0 is sent as 0x20 (leading blank).
- Undefined: 24-hour behaviour as above, leading zero kept, `pm` tied 0.

## Test plan
- Reset, `CLK_HZ`=4, auto-ack each valid char 3 cycles later -> frame 0 chars 0–7 = 30 30 3A 30 30 3A 30 30, then 56 × 0x20, then `frame_start` pulse, index back to 0.
- Run 86400 ticks (`CLK_HZ`=4) from 23:59:58 preset via set pulses -> 23:59:59 then 00:00:00; `sec_tick` count matches elapsed ticks.
- `inc_min` in the same cycle as a seconds-59 tick at 00:05:59 -> 00:06:00, no `sec_tick`, next tick exactly 4 cycles later.
- Hold `sendDone` low 1000 cycles mid-frame with a tick occurring -> `sendData` and index stable, characters 0–7 unchanged until next SNAP.
- Assert `reset` during SEND at index 30 -> `sendDataValid`=0 immediately, time 00:00:00, first char after release = 0x30.
- `TWELVE_HOUR_EN`: from reset, 12 `inc_hour` pulses -> hours 12,1..11,12, `pm` toggles at 11→12, char 0 = 0x20 for hours 1–9.
